// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, reads the combinational instruction memory and
// hands fetched instructions to decode through a single-entry valid/ready register.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Halt,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] ImAddress,
  input  logic [31:0] ImInstruction,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstruction,
  output logic [31:0] OutPC,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] FaultPC,
  output logic [31:0] FetchCount
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;
  localparam logic [1:0] StFault = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;

  logic slot_free;
  logic pc_illegal;

  assign slot_free  = !valid_q || OutReady;
  assign pc_illegal = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= 32'(MEM_WORDS));

  // Next-state: redirect beats the fault check, which beats capture; halt applies afterwards.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    out_pc_d   = out_pc_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    case (state_q)
      StIdle: begin
        if (Start) state_d = StRun;
      end
      StRun: begin
        if (Redirect) begin
          // Drops the entry even if decode is accepting it this cycle.
          valid_d = 1'b0;
          pc_d    = RedirectPC;
          if (Halt) state_d = StHalt;
        end else if (slot_free && pc_illegal) begin
          state_d    = StFault;
          fault_pc_d = pc_q;
          valid_d    = 1'b0;
        end else begin
          if (slot_free) begin
            instr_d  = ImInstruction;
            out_pc_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
          end
          if (Halt) state_d = StHalt;
        end
      end
      StHalt: begin
        // Pending entry stays visible until decode takes it.
        if (valid_q && OutReady) valid_d = 1'b0;
        if (Start) state_d = StRun;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      out_pc_q   <= 32'd0;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      out_pc_q   <= out_pc_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  // Outputs are direct views of state.
  always_comb begin
    ImAddress      = pc_q;
    OutValid       = valid_q;
    OutInstruction = instr_q;
    OutPC          = out_pc_q;
    Halted         = (state_q == StHalt);
    Fault          = (state_q == StFault);
    FaultPC        = fault_pc_q;
    FetchCount     = count_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small combinational instruction memory.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Halt, Redirect, OutReady;
  logic [31:0] RedirectPC, ImAddress, ImInstruction;
  logic        OutValid, Halted, Fault;
  logic [31:0] OutInstruction, OutPC, FaultPC, FetchCount;

  logic [31:0] mem [128];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  fetch_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(128)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .ImAddress(ImAddress), .ImInstruction(ImInstruction),
    .OutValid(OutValid), .OutReady(OutReady), .OutInstruction(OutInstruction),
    .OutPC(OutPC), .Halted(Halted), .Fault(Fault), .FaultPC(FaultPC),
    .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    if (ImAddress[31:9] == 23'd0) ImInstruction = mem[ImAddress[8:2]];
    else ImInstruction = 32'hDEAD_BEEF;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_valid"}, {31'd0, OutValid}, 32'd0);
    check_val({tag, "_instr"}, OutInstruction, 32'd0);
    check_val({tag, "_outpc"}, OutPC, 32'd0);
    check_val({tag, "_halted"}, {31'd0, Halted}, 32'd0);
    check_val({tag, "_fault"}, {31'd0, Fault}, 32'd0);
    check_val({tag, "_faultpc"}, FaultPC, 32'd0);
    check_val({tag, "_count"}, FetchCount, 32'd0);
    check_val({tag, "_imaddr"}, ImAddress, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'h0000_0000;  // nop
    mem[1]  = 32'h2008_0064;  // addi $t0,$zero,100
    mem[2]  = 32'h2009_0001;
    mem[3]  = 32'h0109_5020;
    mem[11] = 32'h0800_0000;  // j 0

    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Redirect = 1'b0;
    RedirectPC = 32'd0; OutReady = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    check_reset_vals("reset");

    // Start: first capture one cycle after Start is sampled.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check_val("start_novalid", {31'd0, OutValid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("seq_valid", {31'd0, OutValid}, 32'd1);
      check_val("seq_pc", OutPC, 32'(i * 4));
      check_val("seq_instr", OutInstruction, mem[i]);
    end

    // Backpressure while 0x8 is held.
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("bp_pc", OutPC, 32'h8);
      check_val("bp_instr", OutInstruction, 32'h2009_0001);
      check_val("bp_valid", {31'd0, OutValid}, 32'd1);
      check_val("bp_imaddr", ImAddress, 32'hC);
    end
    OutReady = 1'b1;
    for (int i = 3; i < 12; i++) begin
      tick();
      check_val("seq2_pc", OutPC, 32'(i * 4));
      check_val("seq2_instr", OutInstruction, mem[i]);
    end
    check_val("count12", FetchCount, 32'd12);

    // Redirect while 0x2C is being accepted.
    Redirect = 1'b1; RedirectPC = 32'h4;
    tick();
    Redirect = 1'b0;
    check_val("redir_valid", {31'd0, OutValid}, 32'd0);
    check_val("redir_count", FetchCount, 32'd12);
    tick();
    check_val("redir_pc", OutPC, 32'h4);
    check_val("redir_instr", OutInstruction, 32'h2008_0064);
    check_val("redir_count2", FetchCount, 32'd13);

    // Halt with a stalled entry, drain, resume.
    OutReady = 1'b0; Halt = 1'b1;
    tick();
    Halt = 1'b0;
    check_val("halt_halted", {31'd0, Halted}, 32'd1);
    check_val("halt_hold_pc", OutPC, 32'h4);
    check_val("halt_hold_valid", {31'd0, OutValid}, 32'd1);
    tick();
    check_val("halt_hold2_valid", {31'd0, OutValid}, 32'd1);
    OutReady = 1'b1;
    tick();
    check_val("halt_drain_valid", {31'd0, OutValid}, 32'd0);
    check_val("halt_drain_count", FetchCount, 32'd13);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check_val("resume_halted", {31'd0, Halted}, 32'd0);
    tick();
    check_val("resume_pc", OutPC, 32'h8);
    check_val("resume_valid", {31'd0, OutValid}, 32'd1);
    check_val("resume_count", FetchCount, 32'd14);

    // Reset mid-RUN with a valid entry.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_reset_vals("midreset");

    // Out-of-range redirect target faults on the next fetch attempt.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    check_val("f1_valid", {31'd0, OutValid}, 32'd1);
    Redirect = 1'b1; RedirectPC = 32'h200;
    tick();
    Redirect = 1'b0;
    check_val("f1_nofault", {31'd0, Fault}, 32'd0);
    tick();
    check_val("f1_fault", {31'd0, Fault}, 32'd1);
    check_val("f1_faultpc", FaultPC, 32'h200);
    check_val("f1_valid0", {31'd0, OutValid}, 32'd0);
    Start = 1'b1; Redirect = 1'b1; RedirectPC = 32'h0; Halt = 1'b1;
    tick(); tick();
    Start = 1'b0; Redirect = 1'b0; Halt = 1'b0;
    check_val("f1_stuck", {31'd0, Fault}, 32'd1);
    check_val("f1_stuck_pc", ImAddress, 32'h200);
    check_val("f1_stuck_valid", {31'd0, OutValid}, 32'd0);
    check_val("f1_stuck_faultpc", FaultPC, 32'h200);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_reset_vals("f1_reset");

    // Misaligned target.
    Start = 1'b1;
    tick();
    Start = 1'b0; Redirect = 1'b1; RedirectPC = 32'h6;
    tick();
    Redirect = 1'b0;
    tick();
    check_val("f2_fault", {31'd0, Fault}, 32'd1);
    check_val("f2_faultpc", FaultPC, 32'h6);
    check_val("f2_count", FetchCount, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
